// File: rtl/sdram_arbit_if.sv
// SDRAM pin bundle between the command arbiter and the top-level pad/tristate logic.
//   sdram_cke                               clock enable
//   sdram_cs_n/ras_n/cas_n/we_n             command pins
//   sdram_bank[1:0], sdram_addr[11:0]       bank and address pins
//   sdram_dq_out[15:0], sdram_dq_oe         write data and tristate enable
//   sdram_dq_in[15:0]                       data returned from the tristate
// master: the arbiter driving the pins; slave: the pad side.
interface sdram_arbit_if;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic [15:0] sdram_dq_in;

    modport master (
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe,
        input  sdram_dq_in
    );

    modport slave (
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe,
        output sdram_dq_in
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter and pin driver.
// Owns the auto-refresh interval timer, grants the bus to one engine at a time
// (refresh > write > read) and registers the owner's command/address/bank/data
// onto the SDRAM pins.
//   clk, rst                  clock and synchronous active-high reset
//   flag_init_end, init_*     init engine done flag and command/address
//   ref_req/ref_en, ref_*     refresh due, refresh grant, refresh engine bus
//   wr_req/wr_en, wr_*        write request/grant, write engine bus and data
//   rd_req/rd_en, rd_*        read request/grant, read engine bus
//   rd_data                   sdram_dq_in registered every cycle
//   sdram                     SDRAM pin bundle (master side)
module sdram_arbit #(
    parameter int unsigned REF_PERIOD = 780,
    parameter int unsigned REF_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    output logic        ref_req,
    output logic        ref_en,
    input  logic        flag_ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [11:0] ref_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic [15:0] rd_data,
    sdram_arbit_if.master sdram
);

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned DQ_W   = 16;

    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_PERIOD - 1);

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    state_t              state_q,   state_d;
    logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                ref_req_q, ref_req_d;
    logic                ref_wrap;
    logic                cke_q,     cke_d;
    logic [CMD_W-1:0]    cmd_q,     cmd_d;
    logic [BANK_W-1:0]   bank_q,    bank_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DQ_W-1:0]     dq_out_q,  dq_out_d;
    logic                dq_oe_q,   dq_oe_d;
    logic [DQ_W-1:0]     rd_data_q, rd_data_d;

    // Next state, refresh timer and pin mux.
    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        ref_req_d = ref_req_q;
        ref_wrap  = 1'b0;
        cke_d     = 1'b1;
        cmd_d     = CMD_NOP;
        bank_d    = '0;
        addr_d    = '0;
        dq_out_d  = wr_data;
        dq_oe_d   = (state_q == S_WRITE);
        rd_data_d = sdram.sdram_dq_in;

        // Owner holds the bus until its own end flag; others are ignored.
        case (state_q)
            S_INIT:  if (flag_init_end) state_d = S_ARBIT;
            S_ARBIT: begin
                if (ref_req_q)   state_d = S_AREF;
                else if (wr_req) state_d = S_WRITE;
                else if (rd_req) state_d = S_READ;
            end
            S_AREF:  if (flag_ref_end) state_d = S_ARBIT;
            S_WRITE: if (flag_wr_end)  state_d = S_ARBIT;
            S_READ:  if (flag_rd_end)  state_d = S_ARBIT;
            default: state_d = S_INIT;
        endcase

        // Free-running interval timer, parked at 0 until init completes.
        if (state_q == S_INIT) begin
            ref_cnt_d = '0;
        end else if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            ref_wrap  = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
        end

        // A wrap while already pending collapses into the one request.
        if (ref_wrap)
            ref_req_d = 1'b1;
        else if (state_q == S_ARBIT && state_d == S_AREF)
            ref_req_d = 1'b0;

        case (state_q)
            S_INIT: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
            end
            S_AREF: begin
                cmd_d  = ref_cmd;
                addr_d = ref_addr;
            end
            S_WRITE: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
                bank_d = wr_bank;
            end
            S_READ: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
                bank_d = rd_bank;
            end
            default: ;
        endcase
    end

    // State, timer and pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            ref_cnt_q <= '0;
            ref_req_q <= 1'b0;
            cke_q     <= 1'b0;
            cmd_q     <= CMD_NOP;
            bank_q    <= '0;
            addr_q    <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            ref_req_q <= ref_req_d;
            cke_q     <= cke_d;
            cmd_q     <= cmd_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign ref_req = ref_req_q;
    assign ref_en  = (state_q == S_AREF);
    assign wr_en   = (state_q == S_WRITE);
    assign rd_en   = (state_q == S_READ);
    assign rd_data = rd_data_q;

    assign sdram.sdram_cke    = cke_q;
    assign sdram.sdram_cs_n   = cmd_q[3];
    assign sdram.sdram_ras_n  = cmd_q[2];
    assign sdram.sdram_cas_n  = cmd_q[1];
    assign sdram.sdram_we_n   = cmd_q[0];
    assign sdram.sdram_bank   = bank_q;
    assign sdram.sdram_addr   = addr_q;
    assign sdram.sdram_dq_out = dq_out_q;
    assign sdram.sdram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: randomized engine traffic drives a
// behavioural model that predicts every output for the following cycle; a
// monitor compares the DUT against those predictions on the falling edge.
module tb_sdram_arbit;
    localparam int REF_PERIOD = 780;
    localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic        clk;
    logic        rst;
    logic        flag_init_end, flag_ref_end, flag_wr_end, flag_rd_end;
    logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic [11:0] init_addr, ref_addr, wr_addr, rd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic [15:0] wr_data, rd_data;
    logic        wr_req, rd_req;
    logic        ref_req, ref_en, wr_en, rd_en;

    sdram_arbit_if sdram_bus();

    sdram_arbit #(.REF_PERIOD(780), .REF_W(10)) dut (
        .clk(clk), .rst(rst),
        .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data(rd_data),
        .sdram(sdram_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {ref_req, ref_en, wr_en, rd_en, cke, cmd[3:0], bank[1:0], addr[11:0],
    //  dq_out[15:0], dq_oe, rd_data[15:0]}
    typedef struct {
        int          cyc;
        logic [55:0] v;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, cycles since init ended, refresh pending.
    int          m_owner = O_INIT;
    int          m_since = 0;
    bit          m_refp  = 1'b0;
    logic [55:0] m_exp;

    function automatic logic [55:0] dut_obs();
        return {ref_req, ref_en, wr_en, rd_en, sdram_bus.sdram_cke,
                sdram_bus.sdram_cs_n, sdram_bus.sdram_ras_n,
                sdram_bus.sdram_cas_n, sdram_bus.sdram_we_n,
                sdram_bus.sdram_bank, sdram_bus.sdram_addr,
                sdram_bus.sdram_dq_out, sdram_bus.sdram_dq_oe, rd_data};
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_update();
        logic [3:0]  pc;
        logic [11:0] pa;
        logic [1:0]  pb;
        int          nxt;
        bit          wrap;
        bit          was_wr;
        if (rst) begin
            m_owner = O_INIT;
            m_since = 0;
            m_refp  = 1'b0;
            m_exp   = {4'b0000, 1'b0, 4'b0111, 2'b00, 12'h000, 16'h0000, 1'b0, 16'h0000};
            return;
        end
        pc = 4'b0111; pa = 12'h000; pb = 2'b00;
        if (m_owner == O_INIT) begin pc = init_cmd; pa = init_addr; end
        if (m_owner == O_REF)  begin pc = ref_cmd;  pa = ref_addr;  end
        if (m_owner == O_WR)   begin pc = wr_cmd;   pa = wr_addr; pb = wr_bank; end
        if (m_owner == O_RD)   begin pc = rd_cmd;   pa = rd_addr; pb = rd_bank; end
        was_wr = (m_owner == O_WR);

        nxt = m_owner;
        if (m_owner == O_INIT && flag_init_end) nxt = O_IDLE;
        if (m_owner == O_IDLE) nxt = m_refp ? O_REF : wr_req ? O_WR : rd_req ? O_RD : O_IDLE;
        if (m_owner == O_REF && flag_ref_end) nxt = O_IDLE;
        if (m_owner == O_WR  && flag_wr_end)  nxt = O_IDLE;
        if (m_owner == O_RD  && flag_rd_end)  nxt = O_IDLE;

        if (m_owner == O_INIT) m_since = 0;
        else m_since = m_since + 1;
        wrap = (m_owner != O_INIT) && (m_since % REF_PERIOD == 0);
        if (wrap) m_refp = 1'b1;
        else if (m_owner == O_IDLE && nxt == O_REF) m_refp = 1'b0;
        m_owner = nxt;

        m_exp = {m_refp, m_owner == O_REF, m_owner == O_WR, m_owner == O_RD, 1'b1,
                 pc, pb, pa, wr_data, was_wr, sdram_bus.sdram_dq_in};
    endfunction

    // One stimulus cycle: drive flags, randomize buses, predict the next cycle.
    task automatic step(input bit r, input bit f_init, input bit wq, input bit rq,
                        input bit f_ref, input bit f_wr, input bit f_rd);
        @(posedge clk);
        #1;
        rst           = r;
        flag_init_end = f_init;
        wr_req        = wq;
        rd_req        = rq;
        flag_ref_end  = f_ref;
        flag_wr_end   = f_wr;
        flag_rd_end   = f_rd;
        init_cmd  = 4'($urandom);  init_addr = 12'($urandom);
        ref_cmd   = 4'($urandom);  ref_addr  = 12'($urandom);
        wr_cmd    = 4'($urandom);  wr_addr   = 12'($urandom);
        wr_bank   = 2'($urandom);  wr_data   = 16'($urandom);
        rd_cmd    = 4'($urandom);  rd_addr   = 12'($urandom);
        rd_bank   = 2'($urandom);
        sdram_bus.sdram_dq_in = 16'($urandom);
        model_update();
        sb_q.push_back('{cyc + 1, m_exp});
    endtask

    task automatic random_steps(input int n, input bit allow_rst);
        for (int i = 0; i < n; i++) begin
            step(allow_rst && ($urandom_range(0, 599) == 0),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
        end
    endtask

    task automatic bound_fail(input string what);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: target owner not reached within cycle budget", what);
    endtask

    // Monitor: compare each cycle's outputs with the prediction tagged for it.
    initial begin
        exp_t        e;
        logic [55:0] got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e   = sb_q.pop_front();
                got = dut_obs();
                total = total + 1;
                if (got !== e.v) begin
                    bad = bad + 1;
                    $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, got, e.v);
                end
            end
        end
    end

    initial begin
        bit hit;
        rst = 1'b1;
        flag_init_end = 0; flag_ref_end = 0; flag_wr_end = 0; flag_rd_end = 0;
        wr_req = 0; rd_req = 0;
        init_cmd = 4'b0111; ref_cmd = 4'b0111; wr_cmd = 4'b0111; rd_cmd = 4'b0111;
        init_addr = '0; ref_addr = '0; wr_addr = '0; rd_addr = '0;
        wr_bank = '0; rd_bank = '0; wr_data = '0;
        sdram_bus.sdram_dq_in = '0;

        // Reset, init pins pass through, init ends, then run idle into first refresh.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 790; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Random engine traffic with stray end flags and rare resets.
        random_steps(2500, 1'b1);

        // Hold a write across two refresh periods with a read pending.
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step(0, 1, 1, 0, 1, 0, 0);
            hit = (m_owner == O_WR);
        end
        if (!hit) bound_fail("enter_write");
        for (int i = 0; i < 2 * REF_PERIOD + 20; i++) step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);

        // Reset pulsed while a read holds the bus.
        hit = (m_owner == O_RD);
        for (int i = 0; i < 50 && !hit; i++) begin
            step(0, 1, 0, 1, 1, 0, 0);
            hit = (m_owner == O_RD);
        end
        if (!hit) bound_fail("enter_read");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        random_steps(400, 1'b0);

        repeat (3) @(negedge clk);
        total = total + 1;
        if (sb_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d predictions never compared, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
